// File: rtl/lab1_imul_accum_pkg.sv
// Shared types and helpers for the multiplier result accumulator.
// Holds the FSM state encoding and the sizing rule for the term counter.
package lab1_imul_accum_pkg;

   // ACC collects the terms of a group; DONE holds a finished sum for the sink.
   typedef enum logic {
      ACC  = 1'b0,
      DONE = 1'b1
   } accum_state_t;

   // Largest group size the counter sizing is meant to cover.
   localparam int ACCUM_NTERMS_MAX = 255;

   // Term-counter width: one bit more than clog2 so p_nterms == 1 still gets a bit.
   function automatic int accum_count_width(input int nterms);
      return $clog2(nterms) + 1;
   endfunction

endpackage

// File: rtl/lab1_imul_result_accum_dpath.sv
// Accumulator datapath: sum and sticky-carry registers fed by an adder with
// carry-out and a first-term mux that restarts the sum at each new group.
module lab1_imul_result_accum_dpath #(
   parameter int p_nbits = 32
) (
   input  logic               clk,
   input  logic               reset,
   input  logic [p_nbits-1:0] in_msg,
   input  logic               sum_en,
   input  logic               sum_first,
   output logic [p_nbits-1:0] out_msg,
   output logic               out_ovf
);

   logic [p_nbits:0]   add_s;
   logic               carry_s;
   logic [p_nbits-1:0] sum_next_s;
   logic               ovf_next_s;
   logic [p_nbits-1:0] sum_r;
   logic               ovf_r;

   // Adder with an extra top bit to expose the unsigned carry-out.
   assign add_s   = {1'b0, sum_r} + {1'b0, in_msg};
   assign carry_s = add_s[p_nbits];

   // First-term mux: a new group loads the product and clears the carry flag.
   always_comb begin
      sum_next_s = add_s[p_nbits-1:0];
      ovf_next_s = ovf_r | carry_s;
      if (sum_first) begin
         sum_next_s = in_msg;
         ovf_next_s = 1'b0;
      end else begin
         sum_next_s = add_s[p_nbits-1:0];
         ovf_next_s = ovf_r | carry_s;
      end
   end

   // Sum and overflow registers; they drive the outputs directly.
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         sum_r <= {p_nbits{1'b0}};
         ovf_r <= 1'b0;
      end else if (sum_en) begin
         sum_r <= sum_next_s;
         ovf_r <= ovf_next_s;
      end else begin
         sum_r <= sum_r;
         ovf_r <= ovf_r;
      end
   end

   assign out_msg = sum_r;
   assign out_ovf = ovf_r;

endmodule

// File: rtl/lab1_imul_result_accum.sv
// Dot-product reduction of the multiplier response stream: sums each group of
// p_nterms products and emits one sum (with sticky carry flag) per group.
// This module holds the FSM, term counter and handshakes; the datapath is a
// separate block steered by sum_en / sum_first.
module lab1_imul_result_accum
   import lab1_imul_accum_pkg::*;
#(
   parameter int p_nbits  = 32,
   parameter int p_nterms = 4
) (
   input  logic               clk,
   input  logic               reset,
   input  logic               in_val,
   output logic               in_rdy,
   input  logic [p_nbits-1:0] in_msg,
   output logic               out_val,
   input  logic               out_rdy,
   output logic [p_nbits-1:0] out_msg,
   output logic               out_ovf
);

   localparam int             CW         = accum_count_width(p_nterms);
   localparam logic [CW-1:0]  ZERO_COUNT = {CW{1'b0}};
   localparam logic [CW-1:0]  ONE_COUNT  = CW'(1);
   localparam logic [CW-1:0]  LAST_COUNT = CW'(p_nterms - 1);

   accum_state_t  state_r;
   accum_state_t  state_next_s;
   logic [CW-1:0] count_r;
   logic [CW-1:0] count_next_s;
   logic          in_fire_s;
   logic          out_fire_s;
   logic          sum_en_s;
   logic          sum_first_s;

   // In DONE the input is ready exactly when the sink is, so a new group can
   // start in the same cycle the old sum leaves. Held low during reset.
   assign out_val    = (state_r == DONE);
   assign in_rdy     = reset & ((state_r == ACC) | out_rdy);
   assign in_fire_s  = in_val & in_rdy;
   assign out_fire_s = out_val & out_rdy;

   // Next-state, counter and datapath-control decode.
   always_comb begin
      state_next_s = state_r;
      count_next_s = count_r;
      sum_en_s     = 1'b0;
      sum_first_s  = 1'b0;
      case (state_r)
         ACC: begin
            if (in_fire_s) begin
               sum_en_s    = 1'b1;
               sum_first_s = (count_r == ZERO_COUNT);
               if (count_r == LAST_COUNT) begin
                  state_next_s = DONE;
                  count_next_s = ZERO_COUNT;
               end else begin
                  count_next_s = count_r + ONE_COUNT;
               end
            end else begin
               count_next_s = count_r;
            end
         end
         DONE: begin
            if (out_fire_s) begin
               if (in_fire_s) begin
                  // Accepted product is the first term of the next group.
                  sum_en_s    = 1'b1;
                  sum_first_s = 1'b1;
                  if (LAST_COUNT == ZERO_COUNT) begin
                     state_next_s = DONE;
                     count_next_s = ZERO_COUNT;
                  end else begin
                     state_next_s = ACC;
                     count_next_s = ONE_COUNT;
                  end
               end else begin
                  state_next_s = ACC;
                  count_next_s = ZERO_COUNT;
               end
            end else begin
               state_next_s = DONE;
            end
         end
         default: begin
            state_next_s = ACC;
            count_next_s = ZERO_COUNT;
         end
      endcase
   end

   // State and term-counter registers.
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         state_r <= ACC;
         count_r <= ZERO_COUNT;
      end else begin
         state_r <= state_next_s;
         count_r <= count_next_s;
      end
   end

   lab1_imul_result_accum_dpath #(
      .p_nbits (p_nbits)
   ) u_dpath (
      .clk       (clk),
      .reset     (reset),
      .in_msg    (in_msg),
      .sum_en    (sum_en_s),
      .sum_first (sum_first_s),
      .out_msg   (out_msg),
      .out_ovf   (out_ovf)
   );

endmodule

// File: tb/tb_lab1_imul_result_accum.sv
// Directed and randomised checks of the result accumulator: a 4-term build
// for the main scenarios and a 1-term build for the pass-through case.
module tb_lab1_imul_result_accum;

   logic        clk;
   logic        reset;
   logic        in_val, in_rdy, out_val, out_rdy, out_ovf;
   logic [31:0] in_msg, out_msg;
   logic        in_val1, in_rdy1, out_val1, out_rdy1, out_ovf1;
   logic [31:0] in_msg1, out_msg1;

   int vectors;
   int miscompares;

   lab1_imul_result_accum #(.p_nbits(32), .p_nterms(4)) dut (
      .clk(clk), .reset(reset),
      .in_val(in_val), .in_rdy(in_rdy), .in_msg(in_msg),
      .out_val(out_val), .out_rdy(out_rdy), .out_msg(out_msg), .out_ovf(out_ovf)
   );

   lab1_imul_result_accum #(.p_nbits(32), .p_nterms(1)) dut1 (
      .clk(clk), .reset(reset),
      .in_val(in_val1), .in_rdy(in_rdy1), .in_msg(in_msg1),
      .out_val(out_val1), .out_rdy(out_rdy1), .out_msg(out_msg1), .out_ovf(out_ovf1)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   // Offer one product to the 4-term build with the sink ready; report in_rdy.
   task automatic feed(input logic [31:0] v, output logic rdy_seen);
      @(negedge clk);
      in_val  = 1'b1;
      in_msg  = v;
      out_rdy = 1'b1;
      #1;
      rdy_seen = in_rdy;
   endtask

   task automatic test_reset();
      reset = 1'b0;
      in_val = 1'b0; in_msg = 32'd0; out_rdy = 1'b0;
      in_val1 = 1'b0; in_msg1 = 32'd0; out_rdy1 = 1'b0;
      repeat (2) @(negedge clk);
      #1;
      vectors++;
      if ({out_val, in_rdy, out_msg, out_ovf} !== {1'b0, 1'b0, 32'd0, 1'b0}) begin
         miscompares++;
         $display("FAIL reset_state: got val=%b rdy=%b msg=%h ovf=%b expected 0 0 00000000 0",
                  out_val, in_rdy, out_msg, out_ovf);
      end
      @(negedge clk);
      reset = 1'b1;
      #1;
      vectors++;
      if ({out_val, in_rdy} !== {1'b0, 1'b1}) begin
         miscompares++;
         $display("FAIL reset_release: got val=%b rdy=%b expected 0 1", out_val, in_rdy);
      end
   endtask

   task automatic test_basic();
      logic r0, r1, r2, r3;
      feed(32'd3, r0); feed(32'd5, r1); feed(32'd7, r2); feed(32'd9, r3);
      vectors++;
      if ({r0, r1, r2, r3} !== 4'b1111) begin
         miscompares++;
         $display("FAIL basic_in_rdy: got %b expected 1111", {r0, r1, r2, r3});
      end
      @(negedge clk);
      in_val = 1'b0;
      #1;
      vectors++;
      if ({out_val, out_msg, out_ovf, in_rdy} !== {1'b1, 32'd24, 1'b0, 1'b1}) begin
         miscompares++;
         $display("FAIL basic_sum: got val=%b msg=%0d ovf=%b rdy=%b expected 1 24 0 1",
                  out_val, out_msg, out_ovf, in_rdy);
      end
      @(negedge clk);
      #1;
      vectors++;
      if (out_val !== 1'b0) begin
         miscompares++;
         $display("FAIL basic_drain: got out_val=%b expected 0", out_val);
      end
   endtask

   task automatic test_overflow();
      logic r;
      feed(32'hFFFF_FFFF, r); feed(32'd2, r); feed(32'd0, r); feed(32'd0, r);
      @(negedge clk);
      in_val = 1'b0;
      #1;
      vectors++;
      if ({out_val, out_msg, out_ovf} !== {1'b1, 32'h0000_0001, 1'b1}) begin
         miscompares++;
         $display("FAIL ovf_sum: got val=%b msg=%h ovf=%b expected 1 00000001 1",
                  out_val, out_msg, out_ovf);
      end
      feed(32'd1, r); feed(32'd1, r); feed(32'd1, r); feed(32'd1, r);
      @(negedge clk);
      in_val = 1'b0;
      #1;
      vectors++;
      if ({out_val, out_msg, out_ovf} !== {1'b1, 32'd4, 1'b0}) begin
         miscompares++;
         $display("FAIL ovf_cleared: got val=%b msg=%h ovf=%b expected 1 00000004 0",
                  out_val, out_msg, out_ovf);
      end
      @(negedge clk);
   endtask

   task automatic test_backpressure();
      logic r;
      feed(32'd1, r); feed(32'd2, r); feed(32'd3, r); feed(32'd4, r);
      for (int i = 0; i < 5; i++) begin
         @(negedge clk);
         in_val = 1'b1; in_msg = 32'd10; out_rdy = 1'b0;
         #1;
         vectors++;
         if ({out_val, out_msg, in_rdy} !== {1'b1, 32'd10, 1'b0}) begin
            miscompares++;
            $display("FAIL bp_hold[%0d]: got val=%b msg=%0d rdy=%b expected 1 10 0",
                     i, out_val, out_msg, in_rdy);
         end
      end
      @(negedge clk);
      in_val = 1'b1; in_msg = 32'd10; out_rdy = 1'b1;
      #1;
      vectors++;
      if ({out_val, in_rdy, out_msg} !== {1'b1, 1'b1, 32'd10}) begin
         miscompares++;
         $display("FAIL bp_release: got val=%b rdy=%b msg=%0d expected 1 1 10",
                  out_val, in_rdy, out_msg);
      end
      feed(32'd20, r); feed(32'd30, r); feed(32'd40, r);
      @(negedge clk);
      in_val = 1'b0;
      #1;
      vectors++;
      if ({out_val, out_msg, out_ovf} !== {1'b1, 32'd100, 1'b0}) begin
         miscompares++;
         $display("FAIL bp_next_group: got val=%b msg=%0d ovf=%b expected 1 100 0",
                  out_val, out_msg, out_ovf);
      end
      @(negedge clk);
      #1;
      vectors++;
      if (out_val !== 1'b0) begin
         miscompares++;
         $display("FAIL bp_drain: got out_val=%b expected 0", out_val);
      end
   endtask

   task automatic test_streaming();
      for (int k = 0; k < 12; k++) begin
         @(negedge clk);
         in_val = 1'b1; in_msg = 32'(k + 1); out_rdy = 1'b1;
         #1;
         vectors++;
         if (in_rdy !== 1'b1) begin
            miscompares++;
            $display("FAIL stream_rdy[%0d]: got %b expected 1", k, in_rdy);
         end
         vectors++;
         if (k == 4 || k == 8) begin
            if ({out_val, out_msg} !== {1'b1, (k == 4) ? 32'd10 : 32'd26}) begin
               miscompares++;
               $display("FAIL stream_sum[%0d]: got val=%b msg=%0d expected 1 %0d",
                        k, out_val, out_msg, (k == 4) ? 10 : 26);
            end
         end else if (out_val !== 1'b0) begin
            miscompares++;
            $display("FAIL stream_idle[%0d]: got out_val=%b expected 0", k, out_val);
         end
      end
      @(negedge clk);
      in_val = 1'b0;
      #1;
      vectors++;
      if ({out_val, out_msg} !== {1'b1, 32'd42}) begin
         miscompares++;
         $display("FAIL stream_last: got val=%b msg=%0d expected 1 42", out_val, out_msg);
      end
      @(negedge clk);
   endtask

   task automatic test_random_stalls();
      logic [31:0] q_sum[$];
      logic        q_ovf[$];
      logic [32:0] macc;
      logic        movf;
      logic        exp_rdy;
      int          mcount, accepted, cycles;
      mcount = 0; accepted = 0; cycles = 0; macc = 33'd0; movf = 1'b0;
      while ((accepted < 200 || q_sum.size() != 0) && cycles < 5000) begin
         @(negedge clk);
         in_val  = (accepted < 200) ? 1'($urandom_range(0, 1)) : 1'b0;
         in_msg  = $urandom;
         out_rdy = 1'($urandom_range(0, 1));
         #1;
         exp_rdy = (q_sum.size() != 0) ? out_rdy : 1'b1;
         vectors++;
         if ({out_val, in_rdy} !== {(q_sum.size() != 0), exp_rdy}) begin
            miscompares++;
            $display("FAIL rand_hs[%0d]: got val=%b rdy=%b expected %b %b",
                     cycles, out_val, in_rdy, (q_sum.size() != 0), exp_rdy);
         end
         if (out_val && q_sum.size() != 0) begin
            vectors++;
            if ({out_msg, out_ovf} !== {q_sum[0], q_ovf[0]}) begin
               miscompares++;
               $display("FAIL rand_sum[%0d]: got msg=%h ovf=%b expected %h %b",
                        cycles, out_msg, out_ovf, q_sum[0], q_ovf[0]);
            end
         end
         if (q_sum.size() != 0 && out_rdy) begin
            void'(q_sum.pop_front());
            void'(q_ovf.pop_front());
         end
         if (in_val && exp_rdy) begin
            accepted++;
            if (mcount == 0) begin
               macc = {1'b0, in_msg};
               movf = 1'b0;
            end else begin
               macc = {1'b0, macc[31:0]} + {1'b0, in_msg};
               movf = movf | macc[32];
            end
            mcount++;
            if (mcount == 4) begin
               q_sum.push_back(macc[31:0]);
               q_ovf.push_back(movf);
               mcount = 0;
            end
         end
         cycles++;
      end
      vectors++;
      if (accepted != 200 || q_sum.size() != 0) begin
         miscompares++;
         $display("FAIL rand_timeout: got accepted=%0d pending=%0d expected 200 0",
                  accepted, q_sum.size());
      end
      @(negedge clk);
      in_val = 1'b0; out_rdy = 1'b1;
      @(negedge clk);
   endtask

   task automatic test_reset_mid();
      logic r;
      feed(32'd5, r); feed(32'd5, r); feed(32'd5, r); feed(32'd5, r);
      @(negedge clk);
      in_val = 1'b0; out_rdy = 1'b0;
      #1;
      vectors++;
      if ({out_val, out_msg} !== {1'b1, 32'd20}) begin
         miscompares++;
         $display("FAIL rst_pre: got val=%b msg=%0d expected 1 20", out_val, out_msg);
      end
      #2 reset = 1'b0;
      #1;
      vectors++;
      if ({out_val, in_rdy, out_msg, out_ovf} !== {1'b0, 1'b0, 32'd0, 1'b0}) begin
         miscompares++;
         $display("FAIL rst_done_clear: got val=%b rdy=%b msg=%h ovf=%b expected 0 0 00000000 0",
                  out_val, in_rdy, out_msg, out_ovf);
      end
      @(negedge clk);
      reset = 1'b1;
      feed(32'd1, r); feed(32'd1, r);
      @(negedge clk);
      in_val = 1'b0;
      #2 reset = 1'b0;
      #1;
      vectors++;
      if ({out_val, in_rdy, out_msg} !== {1'b0, 1'b0, 32'd0}) begin
         miscompares++;
         $display("FAIL rst_partial_clear: got val=%b rdy=%b msg=%h expected 0 0 00000000",
                  out_val, in_rdy, out_msg);
      end
      @(negedge clk);
      reset = 1'b1;
      feed(32'd1, r); feed(32'd1, r); feed(32'd1, r);
      @(negedge clk);
      in_val = 1'b1; in_msg = 32'd1; out_rdy = 1'b1;
      #1;
      vectors++;
      if (out_val !== 1'b0) begin
         miscompares++;
         $display("FAIL rst_no_stale: got out_val=%b expected 0", out_val);
      end
      @(negedge clk);
      in_val = 1'b0;
      #1;
      vectors++;
      if ({out_val, out_msg, out_ovf} !== {1'b1, 32'd4, 1'b0}) begin
         miscompares++;
         $display("FAIL rst_after: got val=%b msg=%0d ovf=%b expected 1 4 0",
                  out_val, out_msg, out_ovf);
      end
      @(negedge clk);
   endtask

   task automatic test_nterms1();
      logic [31:0] vals [5];
      vals[0] = 32'd7; vals[1] = 32'hFFFF_FFFF; vals[2] = 32'd3;
      vals[3] = 32'd0; vals[4] = 32'd42;
      for (int k = 0; k < 6; k++) begin
         @(negedge clk);
         in_val1  = (k < 5);
         in_msg1  = (k < 5) ? vals[k] : 32'd0;
         out_rdy1 = 1'b1;
         #1;
         vectors++;
         if (in_rdy1 !== 1'b1) begin
            miscompares++;
            $display("FAIL n1_rdy[%0d]: got %b expected 1", k, in_rdy1);
         end
         vectors++;
         if (k == 0) begin
            if (out_val1 !== 1'b0) begin
               miscompares++;
               $display("FAIL n1_idle: got out_val=%b expected 0", out_val1);
            end
         end else if ({out_val1, out_msg1, out_ovf1} !== {1'b1, vals[k-1], 1'b0}) begin
            miscompares++;
            $display("FAIL n1_pass[%0d]: got val=%b msg=%h ovf=%b expected 1 %h 0",
                     k, out_val1, out_msg1, out_ovf1, vals[k-1]);
         end
      end
      @(negedge clk);
      in_val1 = 1'b0;
      #1;
      vectors++;
      if (out_val1 !== 1'b0) begin
         miscompares++;
         $display("FAIL n1_drain: got out_val=%b expected 0", out_val1);
      end
   endtask

   initial begin
      vectors = 0;
      miscompares = 0;
      test_reset();
      test_basic();
      test_overflow();
      test_backpressure();
      test_streaming();
      test_random_stalls();
      test_reset_mid();
      test_nterms1();
      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end

endmodule
